// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency 16-bit memory between the fetch and
// data ports: data wins at grant, no preemption, misaligned and timed-out accesses abort.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_done,
   output logic        if_stall,
   input  logic        dm_rd,
   input  logic        dm_wr,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic [15:0] dm_rdata,
   output logic        dm_done,
   output logic        dm_stall,
   output logic        err,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   // Last WAIT cycle index: the counter holds how many WAIT cycles already passed.
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        owner;
   logic [3:0]  cnt;
   logic        abort;
   logic        dm_req;
   logic        grant;
   logic [15:0] req_addr;

   assign dm_req   = dm_rd | dm_wr;
   assign grant    = dm_req | if_req;
   assign req_addr = dm_req ? dm_addr : if_addr;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = req_addr[0] ? DONE : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (mem_done || cnt == TO_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         cnt       <= 4'd0;
         abort     <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= 16'd0;
         mem_wdata <= 16'd0;
         if_rdata  <= 16'd0;
         dm_rdata  <= 16'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner     <= dm_req;
                  mem_addr  <= req_addr;
                  mem_wdata <= dm_wdata;
                  mem_wr    <= dm_req & dm_wr;
                  abort     <= req_addr[0];
               end
            end
            ISSUE: cnt <= 4'd0;
            WAIT: begin
               if (mem_done) begin
                  // Writes and aborted reads leave the read-data registers alone.
                  if (!mem_wr) begin
                     if (owner) dm_rdata <= mem_rdata;
                     else       if_rdata <= mem_rdata;
                  end
               end else if (cnt == TO_LAST) begin
                  abort <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE:    abort <= 1'b0;
            default: ;
         endcase
      end
   end

   assign mem_en   = (state == ISSUE);
   assign if_done  = (state == DONE) & ~owner;
   assign dm_done  = (state == DONE) & owner;
   assign err      = (state == DONE) & abort;
   assign if_stall = if_req & ~if_done;
   assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// timeout, request-drop and reset-mid-access sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_rd, dm_wr, mem_done;
   logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_done, if_stall, dm_done, dm_stall, err, mem_en, mem_wr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_done(if_done), .if_stall(if_stall),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
      .err(err), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   typedef struct {
      logic        rst, ifq;
      logic [15:0] ifa;
      logic        dmr, dmw;
      logic [15:0] dma, dmwd;
      logic        md;
      logic [15:0] mrd;
      logic        en, wr;
      logic [15:0] ma, mwd;
      logic        ifd, dmd, er, ifs, dms;
      logic [15:0] ifr, dmrd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic iq, input logic [15:0] ia,
                        input logic dr, input logic dw, input logic [15:0] da,
                        input logic [15:0] dwd, input logic md, input logic [15:0] mrd);
      rst = r; if_req = iq; if_addr = ia; dm_rd = dr; dm_wr = dw;
      dm_addr = da; dm_wdata = dwd; mem_done = md; mem_rdata = mrd;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      //            rst ifq ifa      dmr dmw dma      dmwd     md mrd       en wr ma       mwd      ifd dmd er ifs dms ifr      dmrd
      vecs.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000});
      // fetch read, memory answers in the first WAIT cycle
      vecs.push_back('{0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0000});
      vecs.push_back('{0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0000});
      vecs.push_back('{0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0000});
      vecs.push_back('{0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0000});
      // simultaneous fetch + data write; mem_done during ISSUE must be ignored
      vecs.push_back('{0, 1, 16'h0040, 0, 1, 16'h0020, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 1, 16'h0020, 16'h1234, 1, 16'h5555, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 1, 1, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 1, 16'h0020, 16'h1234, 1, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 1, 16'h0020, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 0, 0, 1, 0, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 16'hCAFE, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hBEEF, 16'h0000});
      vecs.push_back('{0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'hCAFE, 16'h0000});
      vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'hCAFE, 16'h0000});
      // no preemption: data read raised while fetch waits on 3-cycle memory
      vecs.push_back('{0, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hCAFE, 16'h0000});
      vecs.push_back('{0, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0, 0, 0, 1, 0, 16'hCAFE, 16'h0000});
      vecs.push_back('{0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'hCAFE, 16'h0000});
      vecs.push_back('{0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'hCAFE, 16'h0000});
      vecs.push_back('{0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'hCAFE, 16'h0000});
      vecs.push_back('{0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 16'h1111, 16'h0000});
      vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h1111, 16'h0000});
      vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 0, 0, 0, 1, 16'h1111, 16'h0000});
      vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 1, 16'h2222, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h1111, 16'h0000});
      vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h1111, 16'h2222});
      vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h1111, 16'h2222});
      // misaligned data read: no memory access, done+err next cycle
      vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0003, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h1111, 16'h2222});
      vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0003, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 16'h1111, 16'h2222});
      vecs.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h1111, 16'h2222});

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].ifq, vecs[i].ifa, vecs[i].dmr, vecs[i].dmw,
               vecs[i].dma, vecs[i].dmwd, vecs[i].md, vecs[i].mrd);
         @(negedge clk);
         chk($sformatf("v%0d mem_en", i), 16'(mem_en), 16'(vecs[i].en));
         if (vecs[i].en) begin
            chk($sformatf("v%0d mem_wr", i), 16'(mem_wr), 16'(vecs[i].wr));
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ma);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
         end
         chk($sformatf("v%0d if_done", i), 16'(if_done), 16'(vecs[i].ifd));
         chk($sformatf("v%0d dm_done", i), 16'(dm_done), 16'(vecs[i].dmd));
         chk($sformatf("v%0d err", i), 16'(err), 16'(vecs[i].er));
         chk($sformatf("v%0d if_stall", i), 16'(if_stall), 16'(vecs[i].ifs));
         chk($sformatf("v%0d dm_stall", i), 16'(dm_stall), 16'(vecs[i].dms));
         chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].ifr);
         chk($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].dmrd);
         @(posedge clk);
         #1;
      end

      // timeout: grant, ISSUE, 15 silent WAIT cycles, then DONE with err
      drive(0, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000, 0, 16'h0000);
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         chk($sformatf("to%0d mem_en", c), 16'(mem_en), 16'(c == 1));
         chk($sformatf("to%0d dm_done", c), 16'(dm_done), 16'(c == 17));
         chk($sformatf("to%0d err", c), 16'(err), 16'(c == 17));
         @(posedge clk);
         #1;
      end
      chk("to dm_rdata kept", dm_rdata, 16'h2222);

      // next request served after timeout; fetch dropped during ISSUE still completes
      drive(0, 1, 16'h0400, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      chk("drop mem_en", 16'(mem_en), 16'h1);
      chk("drop mem_addr", mem_addr, 16'h0400);
      @(posedge clk); #1;
      mem_done = 1'b1; mem_rdata = 16'hABCD;
      @(posedge clk); #1;
      mem_done = 1'b0; mem_rdata = 16'h0000;
      @(negedge clk);
      chk("drop if_done", 16'(if_done), 16'h1);
      chk("drop if_rdata", if_rdata, 16'hABCD);
      chk("drop err", 16'(err), 16'h0);
      @(posedge clk); #1;

      // reset during WAIT of a data write, then a late mem_done
      drive(0, 0, 16'h0000, 0, 1, 16'h0500, 16'h9999, 0, 16'h0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h4444);
      @(negedge clk);
      chk("rst mem_en", 16'(mem_en), 16'h0);
      chk("rst mem_wr", 16'(mem_wr), 16'h0);
      chk("rst mem_addr", mem_addr, 16'h0000);
      chk("rst mem_wdata", mem_wdata, 16'h0000);
      chk("rst if_rdata", if_rdata, 16'h0000);
      chk("rst dm_rdata", dm_rdata, 16'h0000);
      chk("rst err", 16'(err), 16'h0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         mem_done = 1'b0;
         @(negedge clk);
         chk($sformatf("rst%0d dm_done", c), 16'(dm_done), 16'h0);
         chk($sformatf("rst%0d if_done", c), 16'(if_done), 16'h0);
         chk($sformatf("rst%0d mem_en", c), 16'(mem_en), 16'h0);
         chk($sformatf("rst%0d dm_rdata", c), dm_rdata, 16'h0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
